paddle_ctrl: RTL and testbench
==============================

PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter DEBOUNCE, default 16: cycles a synchronized encoder input must be stable before acceptance (range 1..255).
REQ-002 Parameter AI_DIV, default 65536: clock cycles per auto-play tick (range 2..2^24).
REQ-003 Parameter HOLDOFF, default 8: auto-play ticks during which auto-play is suppressed after a manual step (range 0..255).
REQ-004 Parameter MIN_GAP, default 2: minimum clock cycles between successive encoder_value changes (range 1..15).
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 enc_a, enc_b  in  1 each  raw asynchronous quadrature pins.
REQ-008 auto_en  in  1  enables auto-play requester.
REQ-009 ball_x  in  5  ball column, 0..31, bit index in paddle vector.
REQ-010 paddle_i  in  32  current paddle vector, fed back from the paddle block.
REQ-011 encoder_value  out  2  step counter driving the paddle block; +1 = move toward bit 0, -1 = move toward bit 31.
REQ-012 auto_active  out  1  high when auto_en=1 and holdoff counter = 0.
REQ-013 step_o  out  1  one-cycle pulse on each encoder_value change.

Function
REQ-014 enc_a/enc_b SHALL pass through a 2-flop synchronizer per pin before any use.
REQ-015 Debounce: synced {a,b} differing from accepted state SHALL increment a counter; equal resets it; reaching DEBOUNCE SHALL load accepted state and clear counter.
REQ-016 Decode on accepted-state change: 00->01->11->10->00 transitions SHALL raise a down request (+1); reverse transitions an up request (-1); two-bit changes SHALL be ignored (state still updated).
REQ-017 Manual requests SHALL be registered; issue occurs the cycle after the request when the gap counter is 0.
REQ-018 If the gap counter is nonzero, a manual request SHALL be held in a 1-entry pending slot; same-direction requests while pending are dropped; an opposite-direction request clears the slot (net zero).
REQ-019 Auto-play SHALL compute L = index of lowest set bit of paddle_i; at each AI tick with auto_active=1: ball_x < L+3 -> down request, ball_x > L+4 -> up request, else none; paddle_i = 0 -> none.
REQ-020 Priority: pending manual > new manual > auto; an auto request not issuable on its tick SHALL be discarded, never pended.
REQ-021 Edge block: at issue time, a down step with paddle_i[0]=1 or an up step with paddle_i[31]=1 SHALL be dropped (and cleared if pending), with no encoder_value change.
REQ-022 Issue SHALL change encoder_value by exactly +/-1 mod 4 (wrap 11->00, 00->11), pulse step_o, and load gap counter with MIN_GAP-1.
REQ-023 Each manual issue SHALL load holdoff counter with HOLDOFF; it decrements by 1 on each AI tick while nonzero.
REQ-024 AI tick counter SHALL count 0..AI_DIV-1 free-running; tick is the cycle it equals AI_DIV-1.
REQ-025 At most one encoder_value change per cycle under all input combinations.

Reset
REQ-026 On reset: encoder_value=00, step_o=0, synchronizers, accepted state, debounce/gap/holdoff/AI counters = 0, pending slot empty; auto_active = auto_en.
REQ-027 Reset asserted mid-debounce or with a pending step SHALL discard it; no step issues in the cycle reset is high.
REQ-028 If pins read non-00 after reset, debounce/decode SHALL treat it as a normal transition from 00.

Verification
REQ-029 DEBOUNCE=4, pins 00->01 held 10 cycles, paddle centered -> exactly one step_o, encoder_value 00->01.
REQ-030 Pin glitch 00->01 for 3 cycles then back, DEBOUNCE=4 -> no step_o, encoder_value unchanged.
REQ-031 MIN_GAP=4, two down requests 1 cycle apart -> two steps 4 cycles apart; third same-direction request during gap dropped.
REQ-032 paddle_i=0x000000FF, down request -> dropped, no step_o; up request -> encoder_value -1.
REQ-033 auto_en=1, AI_DIV=4, paddle_i=0x000FF000 (L=12), ball_x=2 -> down step every 4 cycles until L=0, then none; manual up step -> auto silent for HOLDOFF ticks.
REQ-034 encoder_value=11 plus down step -> 00; 00 plus up step -> 11.

Source files
------------

// File: rtl/paddle_ctrl.sv
// Paddle step controller: debounced quadrature encoder input plus an auto-play
// requester, merged into a rate-limited, edge-guarded 2-bit step counter.
module paddle_ctrl #(
   parameter int DEBOUNCE = 16,
   parameter int AI_DIV   = 65536,
   parameter int HOLDOFF  = 8,
   parameter int MIN_GAP  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enc_a,
   input  logic        enc_b,
   input  logic        auto_en,
   input  logic [4:0]  ball_x,
   input  logic [31:0] paddle_i,
   output logic [1:0]  encoder_value,
   output logic        auto_active,
   output logic        step_o
);

   localparam int AIW = (AI_DIV > 2) ? $clog2(AI_DIV) : 1;
   localparam logic [AIW-1:0] AI_LAST   = AIW'(AI_DIV - 1);
   localparam logic [7:0]     DEB_LAST  = 8'(DEBOUNCE - 1);
   localparam logic [3:0]     GAP_LOAD  = 4'(MIN_GAP - 1);
   localparam logic [7:0]     HOLD_LOAD = 8'(HOLDOFF);

   logic [1:0]     a_sync, b_sync;
   logic [1:0]     synced;
   logic [1:0]     acc_state;
   logic [7:0]     deb_cnt;
   logic           man_dn, man_up;
   logic           pend_valid, pend_dn;
   logic           pend_valid_n, pend_dn_n;
   logic [3:0]     gap_cnt;
   logic [7:0]     hold_cnt;
   logic [AIW-1:0] ai_cnt;
   logic           ai_tick;
   logic [4:0]     low_idx;
   logic           paddle_nz;
   logic [6:0]     bx, lx;
   logic           auto_dn, auto_up;
   logic           want, want_dn, want_manual, blocked, issue;

   // Forward quadrature order: 00 -> 01 -> 11 -> 10 -> 00 (a "down" step)
   function automatic logic [1:0] gray_next(input logic [1:0] g);
      case (g)
         2'b00:   gray_next = 2'b01;
         2'b01:   gray_next = 2'b11;
         2'b11:   gray_next = 2'b10;
         default: gray_next = 2'b00;
      endcase
   endfunction

   assign synced = {a_sync[1], b_sync[1]};

   // Synchronize, debounce and decode the encoder pins into one-cycle requests
   always_ff @(posedge clk) begin
      if (reset) begin
         a_sync    <= '0;
         b_sync    <= '0;
         acc_state <= '0;
         deb_cnt   <= '0;
         man_dn    <= 1'b0;
         man_up    <= 1'b0;
      end else begin
         a_sync <= {a_sync[0], enc_a};
         b_sync <= {b_sync[0], enc_b};
         man_dn <= 1'b0;
         man_up <= 1'b0;
         if (synced != acc_state) begin
            if (deb_cnt == DEB_LAST) begin
               acc_state <= synced;
               deb_cnt   <= '0;
               man_dn    <= (synced == gray_next(acc_state));
               man_up    <= (acc_state == gray_next(synced));
            end else begin
               deb_cnt <= deb_cnt + 8'd1;
            end
         end else begin
            deb_cnt <= '0;
         end
      end
   end

   // Auto-play aims to keep the ball within columns L+3..L+4 of the paddle
   always_comb begin
      low_idx   = '0;
      paddle_nz = |paddle_i;
      for (int i = 31; i >= 0; i--) begin
         if (paddle_i[i]) low_idx = 5'(i);
      end
   end

   assign ai_tick     = (ai_cnt == AI_LAST);
   assign auto_active = auto_en && (hold_cnt == 8'd0);
   assign bx          = {2'b00, ball_x};
   assign lx          = {2'b00, low_idx};
   assign auto_dn     = auto_active && ai_tick && paddle_nz && (bx < lx + 7'd3);
   assign auto_up     = auto_active && ai_tick && paddle_nz && (bx > lx + 7'd4);

   // Arbitration: pending manual, then fresh manual, then auto; auto is never pended
   always_comb begin
      pend_valid_n = pend_valid;
      pend_dn_n    = pend_dn;
      want         = 1'b0;
      want_dn      = 1'b0;
      want_manual  = 1'b0;
      if (pend_valid && (man_dn || man_up) && (man_dn != pend_dn)) begin
         pend_valid_n = 1'b0;
      end
      if (pend_valid) begin
         if (pend_valid_n && (gap_cnt == 4'd0)) begin
            want         = 1'b1;
            want_dn      = pend_dn;
            want_manual  = 1'b1;
            pend_valid_n = 1'b0;
         end
      end else if (man_dn || man_up) begin
         if (gap_cnt == 4'd0) begin
            want        = 1'b1;
            want_dn     = man_dn;
            want_manual = 1'b1;
         end else begin
            pend_valid_n = 1'b1;
            pend_dn_n    = man_dn;
         end
      end else if ((auto_dn || auto_up) && (gap_cnt == 4'd0)) begin
         want    = 1'b1;
         want_dn = auto_dn;
      end
      blocked = want && (want_dn ? paddle_i[0] : paddle_i[31]);
      issue   = want && !blocked;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         encoder_value <= 2'b00;
         step_o        <= 1'b0;
         gap_cnt       <= '0;
         hold_cnt      <= '0;
         ai_cnt        <= '0;
         pend_valid    <= 1'b0;
         pend_dn       <= 1'b0;
      end else begin
         step_o     <= issue;
         pend_valid <= pend_valid_n;
         pend_dn    <= pend_dn_n;
         ai_cnt     <= ai_tick ? '0 : ai_cnt + AIW'(1);
         if (issue) begin
            encoder_value <= want_dn ? encoder_value + 2'd1 : encoder_value - 2'd1;
         end
         if (issue) begin
            gap_cnt <= GAP_LOAD;
         end else if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
         end
         if (issue && want_manual) begin
            hold_cnt <= HOLD_LOAD;
         end else if (ai_tick && (hold_cnt != 8'd0)) begin
            hold_cnt <= hold_cnt - 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: a slow-debounce instance for encoder/auto-play behaviour
// and a DEBOUNCE=1 instance for back-to-back requests, pending slot and gap timing.
module tb_paddle_ctrl;

   localparam int HOLD_M = 3;
   localparam int DIV_M  = 4;
   localparam int GAP    = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enc_a_m = 1'b0, enc_b_m = 1'b0, auto_en_m = 1'b0;
   logic [4:0]  ball_x_m = 5'd0;
   logic [31:0] paddle_m = 32'h000FF000;
   logic [1:0]  ev_m;
   logic        act_m, step_m;
   logic        enc_a_f = 1'b0, enc_b_f = 1'b0;
   logic [1:0]  ev_f;
   logic        act_f, step_f;

   int vectors = 0, miscompares = 0, cyc = 0;
   int steps_m = 0, steps_f = 0, env_l = 12;
   int q_m[$], q_f[$];
   logic [1:0] q_fev[$];
   logic [1:0] prev_ev_m = 2'b00;

   always #5 clk = ~clk;

   paddle_ctrl #(.DEBOUNCE(4), .AI_DIV(DIV_M), .HOLDOFF(HOLD_M), .MIN_GAP(GAP)) u_dut (
      .clk(clk), .reset(reset), .enc_a(enc_a_m), .enc_b(enc_b_m), .auto_en(auto_en_m),
      .ball_x(ball_x_m), .paddle_i(paddle_m), .encoder_value(ev_m),
      .auto_active(act_m), .step_o(step_m));

   paddle_ctrl #(.DEBOUNCE(1), .AI_DIV(8), .HOLDOFF(0), .MIN_GAP(GAP)) u_fast (
      .clk(clk), .reset(reset), .enc_a(enc_a_f), .enc_b(enc_b_f), .auto_en(1'b0),
      .ball_x(5'd0), .paddle_i(32'h000FF000), .encoder_value(ev_f),
      .auto_active(act_f), .step_o(step_f));

   function automatic logic [1:0] gray(input int p);
      case (p & 3)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   // One clock: sample outputs on the falling edge, then act as the paddle block
   task automatic tick();
      logic [1:0] nxt;
      @(negedge clk);
      cyc++;
      if (step_m) begin
         steps_m++;
         q_m.push_back(cyc);
         nxt = prev_ev_m + 2'd1;
         if (ev_m == nxt) env_l = (env_l > 0) ? env_l - 1 : 0;
         else             env_l = (env_l < 24) ? env_l + 1 : 24;
         prev_ev_m = ev_m;
      end
      if (step_f) begin
         steps_f++;
         q_f.push_back(cyc);
         q_fev.push_back(ev_f);
      end
      paddle_m = 32'h000000FF << env_l;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      prev_ev_m = 2'b00;
      q_m.delete();
      q_f.delete();
      q_fev.delete();
   endtask

   task automatic test_reset();
      {enc_a_m, enc_b_m} = 2'b00;
      {enc_a_f, enc_b_f} = 2'b00;
      auto_en_m = 1'($urandom_range(0, 1));
      do_reset();
      vectors++; if (ev_m !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_ev: got %0d want 0", ev_m); end
      vectors++; if (step_m !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_step: got %0b want 0", step_m); end
      vectors++; if (act_m !== auto_en_m) begin miscompares++; $display("[TB] FAIL reset_auto_active: got %0b want %0b", act_m, auto_en_m); end
      vectors++; if (ev_f !== 2'b00 || step_f !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fast: got ev=%0d step=%0b want 0/0", ev_f, step_f); end
      auto_en_m = ~auto_en_m;
      #1;
      vectors++; if (act_m !== auto_en_m) begin miscompares++; $display("[TB] FAIL auto_active_follow: got %0b want %0b", act_m, auto_en_m); end
      auto_en_m = 1'b0;
   endtask

   task automatic test_debounce();
      int s0;
      env_l = 12;
      {enc_a_m, enc_b_m} = 2'b00;
      do_reset();
      s0 = steps_m;
      {enc_a_m, enc_b_m} = 2'b01;
      repeat (10) tick();
      vectors++; if (steps_m - s0 !== 1) begin miscompares++; $display("[TB] FAIL debounce_steps: got %0d want 1", steps_m - s0); end
      vectors++; if (ev_m !== 2'b01) begin miscompares++; $display("[TB] FAIL debounce_ev: got %0d want 1", ev_m); end
   endtask

   task automatic test_glitch();
      int s0, len;
      env_l = 12;
      {enc_a_m, enc_b_m} = 2'b00;
      do_reset();
      s0 = steps_m;
      len = $urandom_range(1, 3);
      {enc_a_m, enc_b_m} = 2'b01;
      repeat (len) tick();
      {enc_a_m, enc_b_m} = 2'b00;
      repeat (10) tick();
      vectors++; if (steps_m - s0 !== 0) begin miscompares++; $display("[TB] FAIL glitch_steps len=%0d: got %0d want 0", len, steps_m - s0); end
      vectors++; if (ev_m !== 2'b00) begin miscompares++; $display("[TB] FAIL glitch_ev: got %0d want 0", ev_m); end
   endtask

   // Random walk of encoder detents; model tracks paddle column and counter value
   task automatic test_manual_random();
      int pos, l_model, s0, dir, exp_steps;
      logic [1:0] ev_exp;
      pos = 0;
      l_model = $urandom_range(0, 24);
      env_l = l_model;
      ev_exp = 2'b00;
      {enc_a_m, enc_b_m} = 2'b00;
      do_reset();
      for (int n = 0; n < 16; n++) begin
         dir = $urandom_range(0, 1);
         pos = (pos + (dir ? 1 : 3)) % 4;
         {enc_a_m, enc_b_m} = gray(pos);
         s0 = steps_m;
         repeat (9) tick();
         if (dir ? (l_model == 0) : (l_model == 24)) begin
            exp_steps = 0;
         end else begin
            exp_steps = 1;
            ev_exp  = dir ? ev_exp + 2'd1 : ev_exp - 2'd1;
            l_model = dir ? l_model - 1 : l_model + 1;
         end
         vectors++; if (steps_m - s0 !== exp_steps) begin miscompares++; $display("[TB] FAIL manual_steps #%0d dir=%0d L=%0d: got %0d want %0d", n, dir, l_model, steps_m - s0, exp_steps); end
         vectors++; if (ev_m !== ev_exp) begin miscompares++; $display("[TB] FAIL manual_ev #%0d: got %0d want %0d", n, ev_m, ev_exp); end
      end
   endtask

   task automatic test_edge_block();
      int s0;
      env_l = 0;
      {enc_a_m, enc_b_m} = 2'b00;
      do_reset();
      s0 = steps_m;
      {enc_a_m, enc_b_m} = 2'b01;
      repeat (9) tick();
      vectors++; if (steps_m - s0 !== 0 || ev_m !== 2'b00) begin miscompares++; $display("[TB] FAIL edge_down_blocked: got steps=%0d ev=%0d want 0/0", steps_m - s0, ev_m); end
      s0 = steps_m;
      {enc_a_m, enc_b_m} = 2'b00;
      repeat (9) tick();
      vectors++; if (steps_m - s0 !== 1 || ev_m !== 2'b11) begin miscompares++; $display("[TB] FAIL edge_up_wrap: got steps=%0d ev=%0d want 1/3", steps_m - s0, ev_m); end
      s0 = steps_m;
      {enc_a_m, enc_b_m} = 2'b01;
      repeat (9) tick();
      vectors++; if (steps_m - s0 !== 1 || ev_m !== 2'b00) begin miscompares++; $display("[TB] FAIL edge_down_wrap: got steps=%0d ev=%0d want 1/0", steps_m - s0, ev_m); end
      env_l = 24;
      tick();
      s0 = steps_m;
      {enc_a_m, enc_b_m} = 2'b00;
      repeat (9) tick();
      vectors++; if (steps_m - s0 !== 0 || ev_m !== 2'b00) begin miscompares++; $display("[TB] FAIL edge_up_blocked: got steps=%0d ev=%0d want 0/0", steps_m - s0, ev_m); end
   endtask

   task automatic test_back_to_back();
      int dir, pf, s0, sp;
      dir = $urandom_range(0, 1);
      pf = 0;
      {enc_a_f, enc_b_f} = 2'b00;
      do_reset();
      s0 = steps_f;
      for (int k = 0; k < 3; k++) begin
         pf = (pf + (dir ? 1 : 3)) % 4;
         {enc_a_f, enc_b_f} = gray(pf);
         tick();
      end
      repeat (20) tick();
      sp = (q_f.size() >= 2) ? q_f[1] - q_f[0] : -1;
      vectors++; if (steps_f - s0 !== 2) begin miscompares++; $display("[TB] FAIL b2b_steps dir=%0d: got %0d want 2", dir, steps_f - s0); end
      vectors++; if (sp !== GAP) begin miscompares++; $display("[TB] FAIL b2b_spacing: got %0d want %0d", sp, GAP); end
      vectors++; if (q_fev.size() < 1 || q_fev[0] !== (dir ? 2'b01 : 2'b11)) begin miscompares++; $display("[TB] FAIL b2b_first_ev: got %0d want %0d", (q_fev.size() > 0) ? q_fev[0] : 2'bxx, dir ? 1 : 3); end
      vectors++; if (ev_f !== 2'b10) begin miscompares++; $display("[TB] FAIL b2b_ev: got %0d want 2", ev_f); end
   endtask

   task automatic test_cancel();
      int dir, pf, s0;
      dir = $urandom_range(0, 1);
      pf = 0;
      {enc_a_f, enc_b_f} = 2'b00;
      do_reset();
      s0 = steps_f;
      for (int k = 0; k < 3; k++) begin
         pf = (pf + ((k < 2) == (dir == 1) ? 1 : 3)) % 4;
         {enc_a_f, enc_b_f} = gray(pf);
         tick();
      end
      repeat (20) tick();
      vectors++; if (steps_f - s0 !== 1) begin miscompares++; $display("[TB] FAIL cancel_steps dir=%0d: got %0d want 1", dir, steps_f - s0); end
      vectors++; if (ev_f !== (dir ? 2'b01 : 2'b11)) begin miscompares++; $display("[TB] FAIL cancel_ev: got %0d want %0d", ev_f, dir ? 1 : 3); end
   endtask

   task automatic test_reset_pending();
      int s0;
      {enc_a_f, enc_b_f} = 2'b00;
      do_reset();
      s0 = steps_f;
      {enc_a_f, enc_b_f} = 2'b01;
      tick();
      {enc_a_f, enc_b_f} = 2'b11;
      for (int k = 0; k < 10 && steps_f == s0; k++) tick();
      vectors++; if (steps_f - s0 !== 1) begin miscompares++; $display("[TB] FAIL pend_first_step: got %0d want 1", steps_f - s0); end
      tick();
      s0 = steps_f;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++; if (step_f !== 1'b0 || ev_f !== 2'b00) begin miscompares++; $display("[TB] FAIL pend_reset_cycle: got step=%0b ev=%0d want 0/0", step_f, ev_f); end
      repeat (12) tick();
      vectors++; if (steps_f - s0 !== 0 || ev_f !== 2'b00) begin miscompares++; $display("[TB] FAIL pend_discarded: got steps=%0d ev=%0d want 0/0", steps_f - s0, ev_f); end
   endtask

   task automatic test_reset_debounce();
      int s0;
      env_l = 12;
      {enc_a_m, enc_b_m} = 2'b00;
      do_reset();
      s0 = steps_m;
      {enc_a_m, enc_b_m} = 2'b01;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      prev_ev_m = 2'b00;
      vectors++; if (step_m !== 1'b0 || ev_m !== 2'b00) begin miscompares++; $display("[TB] FAIL midbounce_reset: got step=%0b ev=%0d want 0/0", step_m, ev_m); end
      repeat (12) tick();
      vectors++; if (steps_m - s0 !== 1 || ev_m !== 2'b01) begin miscompares++; $display("[TB] FAIL midbounce_restart: got steps=%0d ev=%0d want 1/1", steps_m - s0, ev_m); end
   endtask

   // Auto-play should walk the paddle into the L+3..L+4 window, one step per tick
   task automatic test_auto();
      int l0, lf, b, s0, bad;
      logic [1:0] ev_exp;
      for (int r = 0; r < 4; r++) begin
         l0 = (r == 0) ? 12 : $urandom_range(0, 24);
         b  = (r == 0) ? 2 : $urandom_range(0, 31);
         lf = l0;
         if (b < l0 + 3)      lf = (b - 3 > 0) ? b - 3 : 0;
         else if (b > l0 + 4) lf = (b - 4 < 24) ? b - 4 : 24;
         ev_exp = 2'((l0 - lf) & 3);
         env_l = l0;
         ball_x_m = 5'(b);
         auto_en_m = 1'b1;
         {enc_a_m, enc_b_m} = 2'b00;
         do_reset();
         s0 = steps_m;
         repeat ((((l0 > lf) ? l0 - lf : lf - l0) + 3) * DIV_M + 8) tick();
         bad = 0;
         for (int i = 1; i < q_m.size(); i++) if (q_m[i] - q_m[i-1] != DIV_M) bad++;
         vectors++; if (steps_m - s0 !== ((l0 > lf) ? l0 - lf : lf - l0)) begin miscompares++; $display("[TB] FAIL auto_steps L0=%0d ball=%0d: got %0d want %0d", l0, b, steps_m - s0, (l0 > lf) ? l0 - lf : lf - l0); end
         vectors++; if (ev_m !== ev_exp) begin miscompares++; $display("[TB] FAIL auto_ev L0=%0d ball=%0d: got %0d want %0d", l0, b, ev_m, ev_exp); end
         vectors++; if (bad !== 0) begin miscompares++; $display("[TB] FAIL auto_spacing: got %0d irregular gaps want 0", bad); end
         vectors++; if (env_l !== lf) begin miscompares++; $display("[TB] FAIL auto_final_L: got %0d want %0d", env_l, lf); end
      end
      auto_en_m = 1'b0;
   endtask

   task automatic test_holdoff();
      int d;
      env_l = 12;
      ball_x_m = 5'd15;
      auto_en_m = 1'b1;
      {enc_a_m, enc_b_m} = 2'b00;
      do_reset();
      repeat (8) tick();
      vectors++; if (q_m.size() !== 0 || act_m !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_idle: got steps=%0d active=%0b want 0/1", q_m.size(), act_m); end
      {enc_a_m, enc_b_m} = 2'b10;
      for (int k = 0; k < 12 && q_m.size() == 0; k++) tick();
      vectors++; if (q_m.size() !== 1 || ev_m !== 2'b11) begin miscompares++; $display("[TB] FAIL hold_manual_up: got steps=%0d ev=%0d want 1/3", q_m.size(), ev_m); end
      vectors++; if (act_m !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_active_low: got %0b want 0", act_m); end
      for (int k = 0; k < 30 && q_m.size() < 2; k++) tick();
      d = (q_m.size() >= 2) ? q_m[1] - q_m[0] : -1;
      vectors++; if (d < HOLD_M * DIV_M + 1 || d > (HOLD_M + 1) * DIV_M) begin miscompares++; $display("[TB] FAIL hold_delay: got %0d want %0d..%0d", d, HOLD_M * DIV_M + 1, (HOLD_M + 1) * DIV_M); end
      repeat (20) tick();
      vectors++; if (q_m.size() !== 2 || ev_m !== 2'b00 || env_l !== 12) begin miscompares++; $display("[TB] FAIL hold_settle: got steps=%0d ev=%0d L=%0d want 2/0/12", q_m.size(), ev_m, env_l); end
      auto_en_m = 1'b0;
      #1;
      vectors++; if (act_m !== 1'b0) begin miscompares++; $display("[TB] FAIL auto_disable: got %0b want 0", act_m); end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_glitch();
      test_manual_random();
      test_edge_block();
      test_back_to_back();
      test_cancel();
      test_reset_pending();
      test_reset_debounce();
      test_auto();
      test_holdoff();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
